// File: rtl/clock_ctrl_pkg.sv
// Shared types and BCD limits for the digital clock mode/time-setting controller.
package clock_ctrl_pkg;

   localparam int BCD_W = 4;

   typedef enum logic [1:0] {
      MODE_RUN      = 2'd0,
      MODE_SET_HOUR = 2'd1,
      MODE_SET_MIN  = 2'd2
   } mode_e;

   localparam logic [BCD_W-1:0] HOUR_MAX_CHUC    = 4'd2;
   localparam logic [BCD_W-1:0] HOUR_MAX_DV_AT_2 = 4'd3;
   localparam logic [BCD_W-1:0] MIN_MAX_CHUC     = 4'd5;
   localparam logic [BCD_W-1:0] DV_MAX           = 4'd9;

   localparam int HOUR_MAX = int'(HOUR_MAX_CHUC) * 10 + int'(HOUR_MAX_DV_AT_2);
   localparam int MIN_MAX  = int'(MIN_MAX_CHUC) * 10 + int'(DV_MAX);

   typedef struct packed {
      logic [BCD_W-1:0] hour_chuc;
      logic [BCD_W-1:0] hour_dv;
      logic [BCD_W-1:0] min_chuc;
      logic [BCD_W-1:0] min_dv;
   } bcd_time_t;

endpackage

// File: rtl/clock_ctrl_if.sv
// Controller-side bundle: buttons and live time in, tick/load/preset/mode/blink out.
interface clock_ctrl_if;
   import clock_ctrl_pkg::*;

   logic             btn_mode;
   logic             btn_inc;
   logic [BCD_W-1:0] cur_hour_chuc;
   logic [BCD_W-1:0] cur_hour_dv;
   logic [BCD_W-1:0] cur_min_chuc;
   logic [BCD_W-1:0] cur_min_dv;
   logic             tick;
   logic             load;
   logic [BCD_W-1:0] set_hour_chuc;
   logic [BCD_W-1:0] set_hour_dv;
   logic [BCD_W-1:0] set_min_chuc;
   logic [BCD_W-1:0] set_min_dv;
   logic [1:0]       mode;
   logic             blink;

   modport master (
      input  btn_mode, btn_inc,
      input  cur_hour_chuc, cur_hour_dv, cur_min_chuc, cur_min_dv,
      output tick, load, mode, blink,
      output set_hour_chuc, set_hour_dv, set_min_chuc, set_min_dv
   );

   modport slave (
      output btn_mode, btn_inc,
      output cur_hour_chuc, cur_hour_dv, cur_min_chuc, cur_min_dv,
      input  tick, load, mode, blink,
      input  set_hour_chuc, set_hour_dv, set_min_chuc, set_min_dv
   );

endinterface

// File: rtl/clock_ctrl_bcd2_inc.sv
// Combinational two-digit BCD increment, wrapping to 00 after MAX_VAL (23 or 59).
module bcd2_inc
   import clock_ctrl_pkg::*;
#(
   parameter int MAX_VAL = 59
) (
   input  logic [BCD_W-1:0] chuc_i,
   input  logic [BCD_W-1:0] dv_i,
   output logic [BCD_W-1:0] chuc_o,
   output logic [BCD_W-1:0] dv_o
);

   localparam logic [BCD_W-1:0] MAX_CHUC = BCD_W'(MAX_VAL / 10);
   localparam logic [BCD_W-1:0] MAX_DV   = BCD_W'(MAX_VAL % 10);

   always_comb begin
      chuc_o = chuc_i;
      dv_o   = dv_i + 4'd1;
      if (chuc_i == MAX_CHUC && dv_i == MAX_DV) begin
         chuc_o = '0;
         dv_o   = '0;
      end else if (dv_i >= DV_MAX) begin
         chuc_o = chuc_i + 4'd1;
         dv_o   = '0;
      end
   end

endmodule

// File: rtl/clock_ctrl.sv
// Mode/time-setting controller: count-enable prescaler, RUN/SET_HOUR/SET_MIN editing, preset load.
// Blink generator for the edited field is built only when CLOCK_CTRL_BLINK_EN is defined.
module clock_ctrl
   import clock_ctrl_pkg::*;
#(
   parameter int TICK_DIV  = 50_000_000,
   parameter int BLINK_DIV = 12_500_000
) (
   input logic          clk2,
   input logic          reset,
   clock_ctrl_if.master bus
);

   localparam logic [1:0] ST_RUN      = MODE_RUN;
   localparam logic [1:0] ST_SET_HOUR = MODE_SET_HOUR;
   localparam logic [1:0] ST_SET_MIN  = MODE_SET_MIN;

   localparam int               PRE_W   = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

   if (TICK_DIV < 2 || BLINK_DIV < 2) begin : g_param_check
      $error("clock_ctrl: TICK_DIV and BLINK_DIV must be at least 2");
   end

   logic [1:0]       state_q, state_d;
   logic             btn_mode_q, btn_inc_q;
   logic             mode_press, inc_press;
   bcd_time_t        shadow_q, shadow_d;
   logic             load_q, load_d;
   logic             tick_q, tick_d;
   logic             run_stay;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [BCD_W-1:0] hour_chuc_inc, hour_dv_inc, min_chuc_inc, min_dv_inc;

   bcd2_inc #(.MAX_VAL(HOUR_MAX)) u_hour_inc (
      .chuc_i (shadow_q.hour_chuc),
      .dv_i   (shadow_q.hour_dv),
      .chuc_o (hour_chuc_inc),
      .dv_o   (hour_dv_inc)
   );

   bcd2_inc #(.MAX_VAL(MIN_MAX)) u_min_inc (
      .chuc_i (shadow_q.min_chuc),
      .dv_i   (shadow_q.min_dv),
      .chuc_o (min_chuc_inc),
      .dv_o   (min_dv_inc)
   );

   assign mode_press = bus.btn_mode & ~btn_mode_q;
   // A mode press on the same edge swallows any increment press.
   assign inc_press  = bus.btn_inc & ~btn_inc_q & ~mode_press;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      load_d   = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (mode_press) begin
               state_d            = ST_SET_HOUR;
               shadow_d.hour_chuc = bus.cur_hour_chuc;
               shadow_d.hour_dv   = bus.cur_hour_dv;
               shadow_d.min_chuc  = bus.cur_min_chuc;
               shadow_d.min_dv    = bus.cur_min_dv;
            end
         end
         ST_SET_HOUR: begin
            if (mode_press) begin
               state_d = ST_SET_MIN;
            end else if (inc_press) begin
               shadow_d.hour_chuc = hour_chuc_inc;
               shadow_d.hour_dv   = hour_dv_inc;
            end
         end
         ST_SET_MIN: begin
            if (mode_press) begin
               state_d = ST_RUN;
               load_d  = 1'b1;
            end else if (inc_press) begin
               shadow_d.min_chuc = min_chuc_inc;
               shadow_d.min_dv   = min_dv_inc;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Prescaler only advances while RUN is both current and next, so leaving RUN never ticks.
   always_comb begin
      run_stay = (state_q == ST_RUN) && (state_d == ST_RUN);
      pre_d    = '0;
      tick_d   = 1'b0;
      if (run_stay) begin
         if (pre_q == PRE_MAX) begin
            tick_d = 1'b1;
         end else begin
            pre_d = pre_q + PRE_W'(1);
         end
      end
   end

   // NOTE: clocked state uses <= so every register samples the pre-edge values.
   always_ff @(posedge clk2 or posedge reset) begin
      if (reset) begin
         state_q    <= ST_RUN;
         btn_mode_q <= 1'b1;
         btn_inc_q  <= 1'b1;
         shadow_q   <= '0;
         load_q     <= 1'b0;
         tick_q     <= 1'b0;
         pre_q      <= '0;
      end else begin
         state_q    <= state_d;
         btn_mode_q <= bus.btn_mode;
         btn_inc_q  <= bus.btn_inc;
         shadow_q   <= shadow_d;
         load_q     <= load_d;
         tick_q     <= tick_d;
         pre_q      <= pre_d;
      end
   end

   assign bus.mode          = state_q;
   assign bus.tick          = tick_q;
   assign bus.load          = load_q;
   assign bus.set_hour_chuc = shadow_q.hour_chuc;
   assign bus.set_hour_dv   = shadow_q.hour_dv;
   assign bus.set_min_chuc  = shadow_q.min_chuc;
   assign bus.set_min_dv    = shadow_q.min_dv;

`ifdef CLOCK_CTRL_BLINK_EN
   localparam int               BLK_W   = $clog2(BLINK_DIV);
   localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

   logic [BLK_W-1:0] bcnt_q, bcnt_d;
   logic             blink_q, blink_d;

   // Cleared in RUN and on every SET entry so each edited field starts with blink low.
   always_comb begin
      bcnt_d  = '0;
      blink_d = 1'b0;
      if (state_d != ST_RUN && state_d == state_q) begin
         if (bcnt_q == BLK_MAX) begin
            blink_d = ~blink_q;
         end else begin
            bcnt_d  = bcnt_q + BLK_W'(1);
            blink_d = blink_q;
         end
      end
   end

   always_ff @(posedge clk2 or posedge reset) begin
      if (reset) begin
         bcnt_q  <= '0;
         blink_q <= 1'b0;
      end else begin
         bcnt_q  <= bcnt_d;
         blink_q <= blink_d;
      end
   end

   assign bus.blink = blink_q;
`else
   assign bus.blink = 1'b0;
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: directed scenarios plus random button traffic against a
// value-level model (hours/minutes as integers, tick from cycles elapsed since RUN began).
module tb_clock_ctrl;

   localparam int TICK_DIV  = 4;
   localparam int BLINK_DIV = 3;

   logic clk2 = 1'b0;
   logic reset;

   clock_ctrl_if bus_if ();

   clock_ctrl #(
      .TICK_DIV  (TICK_DIV),
      .BLINK_DIV (BLINK_DIV)
   ) dut (
      .clk2  (clk2),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk2 = ~clk2;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int   m_mode, m_hour, m_min, m_run_cyc, m_set_cyc;
   int   m_cur_h, m_cur_m;
   logic m_prev_mode, m_prev_inc;
   logic exp_tick, exp_load, exp_blink;

   function automatic logic [20:0] obs_vec();
      return {bus_if.tick, bus_if.load, bus_if.mode,
              bus_if.set_hour_chuc, bus_if.set_hour_dv,
              bus_if.set_min_chuc, bus_if.set_min_dv, bus_if.blink};
   endfunction

   function automatic logic [20:0] exp_vec();
      return {exp_tick, exp_load, 2'(m_mode),
              4'(m_hour / 10), 4'(m_hour % 10),
              4'(m_min / 10), 4'(m_min % 10), exp_blink};
   endfunction

   task automatic model_reset();
      m_mode      = 0;
      m_hour      = 0;
      m_min       = 0;
      m_run_cyc   = 0;
      m_set_cyc   = 0;
      m_prev_mode = 1'b1;
      m_prev_inc  = 1'b1;
      exp_tick    = 1'b0;
      exp_load    = 1'b0;
      exp_blink   = 1'b0;
   endtask

   task automatic set_cur(input int h, input int m);
      m_cur_h = h;
      m_cur_m = m;
      bus_if.cur_hour_chuc = 4'(h / 10);
      bus_if.cur_hour_dv   = 4'(h % 10);
      bus_if.cur_min_chuc  = 4'(m / 10);
      bus_if.cur_min_dv    = 4'(m % 10);
   endtask

   // Drive button levels, take one clock edge, and advance the model to match.
   task automatic advance(input logic bm, input logic bi);
      logic mp, ip;
      int   old_mode;
      bus_if.btn_mode = bm;
      bus_if.btn_inc  = bi;
      @(posedge clk2);
      #1;
      mp = bm && !m_prev_mode;
      ip = bi && !m_prev_inc && !mp;
      m_prev_mode = bm;
      m_prev_inc  = bi;
      old_mode = m_mode;
      exp_tick = 1'b0;
      exp_load = 1'b0;
      case (m_mode)
         0: begin
            if (mp) begin
               m_mode = 1;
               m_hour = m_cur_h;
               m_min  = m_cur_m;
            end else begin
               m_run_cyc++;
               exp_tick = ((m_run_cyc % TICK_DIV) == 0);
            end
         end
         1: begin
            if (mp) m_mode = 2;
            else if (ip) m_hour = (m_hour + 1) % 24;
         end
         default: begin
            if (mp) begin
               m_mode    = 0;
               exp_load  = 1'b1;
               m_run_cyc = 0;
            end else if (ip) begin
               m_min = (m_min + 1) % 60;
            end
         end
      endcase
      if (m_mode == 0 || m_mode != old_mode) m_set_cyc = 0;
      else m_set_cyc++;
`ifdef CLOCK_CTRL_BLINK_EN
      exp_blink = (m_mode != 0) && (((m_set_cyc / BLINK_DIV) % 2) == 1);
`else
      exp_blink = 1'b0;
`endif
   endtask

   task automatic do_reset(input logic bm);
      reset = 1'b1;
      bus_if.btn_mode = bm;
      bus_if.btn_inc  = 1'b0;
      repeat (2) @(posedge clk2);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus_if.btn_mode = 1'b0;
      bus_if.btn_inc  = 1'b0;
      set_cur(12, 34);
      model_reset();
      #2;
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL reset_async got %h want %h", obs_vec(), exp_vec());
      end
      repeat (2) @(posedge clk2);
      #1;
      checks++;
      if (obs_vec() !== 21'd0) begin
         errors++;
         $display("FAIL reset_held got %h want %h", obs_vec(), 21'd0);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL reset_release got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_run_tick();
      do_reset(1'b0);
      for (int i = 1; i <= 13; i++) begin
         advance(1'b0, 1'b0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL run_tick cyc %0d got %h want %h", i, obs_vec(), exp_vec());
         end
         checks++;
         if (bus_if.tick !== ((i % 4) == 0) || bus_if.load !== 1'b0) begin
            errors++;
            $display("FAIL run_tick_fixed cyc %0d got tick %b load %b want tick %b load 0",
                     i, bus_if.tick, bus_if.load, (i % 4) == 0);
         end
      end
   endtask

   task automatic test_set_hour();
      logic [1:0] seq [6] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
      set_cur(22, 58);
      for (int i = 0; i < 6; i++) begin
         advance(seq[i][1], seq[i][0]);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL set_hour step %0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      checks++;
      if ({bus_if.mode, bus_if.set_hour_chuc, bus_if.set_hour_dv, bus_if.set_min_chuc,
           bus_if.set_min_dv} !== {2'd1, 4'd0, 4'd0, 4'd5, 4'd8}) begin
         errors++;
         $display("FAIL set_hour_wrap got mode %0d %h%h:%h%h want mode 1 00:58", bus_if.mode,
                  bus_if.set_hour_chuc, bus_if.set_hour_dv, bus_if.set_min_chuc, bus_if.set_min_dv);
      end
   endtask

   task automatic test_set_min_wrap();
      logic [1:0] seq [6] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
      for (int i = 0; i < 6; i++) begin
         advance(seq[i][1], seq[i][0]);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL set_min step %0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      checks++;
      if ({bus_if.mode, bus_if.set_hour_chuc, bus_if.set_hour_dv, bus_if.set_min_chuc,
           bus_if.set_min_dv} !== {2'd2, 4'd0, 4'd0, 4'd0, 4'd0}) begin
         errors++;
         $display("FAIL set_min_wrap got mode %0d %h%h:%h%h want mode 2 00:00", bus_if.mode,
                  bus_if.set_hour_chuc, bus_if.set_hour_dv, bus_if.set_min_chuc, bus_if.set_min_dv);
      end
      advance(1'b1, 1'b0);
      checks++;
      if ({bus_if.load, bus_if.tick, bus_if.mode} !== {1'b1, 1'b0, 2'd0} || obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL load_cycle got %h want %h", obs_vec(), exp_vec());
      end
      for (int i = 0; i < 9; i++) begin
         advance(1'b0, 1'b0);
         checks++;
         if (bus_if.tick !== (i == 3 || i == 7) || bus_if.load !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL tick_after_load cyc %0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [1:0] seq [6] = '{2'b10, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00};
      set_cur(13, 7);
      for (int i = 0; i < 6; i++) begin
         advance(seq[i][1], seq[i][0]);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL simultaneous step %0d got %h want %h", i, obs_vec(), exp_vec());
         end
         if (i == 3) begin
            checks++;
            if ({bus_if.mode, bus_if.set_hour_chuc, bus_if.set_hour_dv} !== {2'd2, 4'd1, 4'd3}) begin
               errors++;
               $display("FAIL simultaneous_fixed got mode %0d hour %h%h want mode 2 hour 13",
                        bus_if.mode, bus_if.set_hour_chuc, bus_if.set_hour_dv);
            end
         end
      end
   endtask

   task automatic test_held_reset();
      logic [1:0] seq [7] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
      set_cur(4, 20);
      do_reset(1'b1);
      for (int i = 0; i < 5; i++) begin
         advance(1'b1, 1'b0);
         checks++;
         if (bus_if.mode !== 2'd0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL held_reset cyc %0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      for (int i = 0; i < 7; i++) begin
         advance(seq[i][1], seq[i][0]);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL held_release step %0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid_edit();
      logic [1:0] seq [6] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
      set_cur(9, 45);
      for (int i = 0; i < 6; i++) begin
         advance(seq[i][1], seq[i][0]);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL mid_edit step %0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      reset = 1'b1;
      #1;
      model_reset();
      checks++;
      if (obs_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL mid_edit_abort got %h want %h", obs_vec(), exp_vec());
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk2);
         #1;
         checks++;
         if (bus_if.load !== 1'b0 || bus_if.mode !== 2'd0) begin
            errors++;
            $display("FAIL mid_edit_in_reset cyc %0d got load %b mode %0d want load 0 mode 0",
                     i, bus_if.load, bus_if.mode);
         end
      end
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         advance(1'b0, 1'b0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL mid_edit_after cyc %0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_blink();
      int lens [3] = '{10, 7, 4};
      set_cur(5, 5);
      for (int s = 0; s < 3; s++) begin
         advance(1'b1, 1'b0);
         checks++;
         if (bus_if.blink !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL blink_entry seg %0d got %h want %h", s, obs_vec(), exp_vec());
         end
         for (int i = 0; i < lens[s]; i++) begin
            advance(1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
               errors++;
               $display("FAIL blink seg %0d cyc %0d got %h want %h", s, i, obs_vec(), exp_vec());
            end
         end
      end
   endtask

   task automatic test_random();
      logic bm, bi;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) set_cur($urandom_range(0, 23), $urandom_range(0, 59));
         bm = ($urandom_range(0, 4) == 0);
         bi = ($urandom_range(0, 2) == 0);
         advance(bm, bi);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random cyc %0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_run_tick();
      test_set_hour();
      test_set_min_wrap();
      test_simultaneous();
      test_held_reset();
      test_reset_mid_edit();
      test_blink();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
